video_timing_gen: RTL and testbench

Raster timing generator that sits directly upstream of the grid pixel stage. It produces the hcount/vcount position consumed by the pixel generators, plus hsync, vsync and blank for the VGA output. All outputs are registered and mutually coherent, so every output in a given cycle describes the same raster position. It also provides a one-cycle start-of-frame strobe and a free-running frame counter, which downstream animation logic uses.

---
 rtl/video_timing_gen.sv | 101 ++++++++++
 tb/tb_video_timing_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: walks the (hcount, vcount) position over the full
// frame and registers sync, blank and start-of-frame alongside it, so every
// output in a cycle describes the same raster position.
module video_timing_gen #(
  parameter int H_ACTIVE  = 1024,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BP      = 160,
  parameter int V_ACTIVE  = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 29,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        en_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out,
  output logic        new_frame_out,
  output logic [5:0]  frame_count_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_FIRST   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Column counter with wrap at the end of the line.
  function automatic logic [10:0] h_inc(input logic [10:0] h);
    return (h == H_LAST) ? 11'd0 : h + 11'd1;
  endfunction

  // Line counter with wrap at the end of the frame.
  function automatic logic [9:0] v_inc(input logic [9:0] v);
    return (v == V_LAST) ? 10'd0 : v + 10'd1;
  endfunction

  logic [10:0] h_next;
  logic [9:0]  v_next;
  logic        h_wrap;
  logic        frame_entry;
  logic        hs_act;
  logic        vs_act;
  logic        blank_next;
  // Cleared by reset so the first entry into (0,0) does not count a frame.
  logic        started_q;

  // Next raster position and the sync/blank decode of that position.
  always_comb begin
    h_wrap      = (hcount_out == H_LAST);
    h_next      = h_inc(hcount_out);
    v_next      = h_wrap ? v_inc(vcount_out) : vcount_out;
    frame_entry = h_wrap && (vcount_out == V_LAST);
    hs_act      = (h_next >= HS_FIRST) && (h_next <= HS_LAST);
    vs_act      = (v_next >= VS_FIRST) && (v_next <= VS_LAST);
    blank_next  = (h_next >= H_ACT_END) || (v_next >= V_ACT_END);
  end

  // Registered raster state; reset parks the position at the last pixel so the
  // first enabled edge lands on (0,0) and is flagged as a new frame.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      hcount_out      <= H_LAST;
      vcount_out      <= V_LAST;
      hsync_out       <= ~HSYNC_POL;
      vsync_out       <= ~VSYNC_POL;
      blank_out       <= 1'b1;
      new_frame_out   <= 1'b0;
      frame_count_out <= 6'd0;
      started_q       <= 1'b0;
    end else if (en_in) begin
      hcount_out    <= h_next;
      vcount_out    <= v_next;
      hsync_out     <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      vsync_out     <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      blank_out     <= blank_next;
      new_frame_out <= frame_entry;
      if (frame_entry) begin
        if (started_q) begin
          frame_count_out <= frame_count_out + 6'd1;
        end
        started_q <= 1'b1;
      end
    end else begin
      new_frame_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: a small 8x6 raster configuration for
// the functional and corner cases, plus a default-parameter instance for the
// line-level sync/blank boundaries.
module tb_video_timing_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic [10:0] hc;
  logic [9:0]  vc;
  logic        hs, vs, bl, nf;
  logic [5:0]  fc;

  logic        rst2;
  logic        en2;
  logic [10:0] hc2;
  logic [9:0]  vc2;
  logic        hs2, vs2, bl2, nf2;
  logic [5:0]  fc2;

  int n_checks = 0;
  int n_fail   = 0;

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) u_small (
    .pixel_clk_in(clk), .rst_in(rst), .en_in(en),
    .hcount_out(hc), .vcount_out(vc), .hsync_out(hs), .vsync_out(vs),
    .blank_out(bl), .new_frame_out(nf), .frame_count_out(fc)
  );

  video_timing_gen u_def (
    .pixel_clk_in(clk), .rst_in(rst2), .en_in(en2),
    .hcount_out(hc2), .vcount_out(vc2), .hsync_out(hs2), .vsync_out(vs2),
    .blank_out(bl2), .new_frame_out(nf2), .frame_count_out(fc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit en;
    int h;
    int v;
    bit hs;
    bit vs;
    bit bl;
    bit nf;
    int fc;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input bit e);
    en = e;
    @(posedge clk);
    #1;
  endtask

  // Expected small-config outputs for the n-th enabled edge of a frame.
  task automatic chk_small_pos(input string tag, input int n);
    int eh, ev;
    eh = n % 8;
    ev = (n / 8) % 6;
    chk({tag, " hcount"}, int'(hc), eh);
    chk({tag, " vcount"}, int'(vc), ev);
    chk({tag, " hsync"}, int'(hs), (eh == 5 || eh == 6) ? 0 : 1);
    chk({tag, " vsync"}, int'(vs), (ev == 4) ? 0 : 1);
    chk({tag, " blank"}, int'(bl), (eh >= 4 || ev >= 3) ? 1 : 0);
    chk({tag, " new_frame"}, int'(nf), (n % 48 == 0) ? 1 : 0);
  endtask

  initial begin
    int pulses;
    int nsteps;

    //            en  h  v  hs vs bl nf fc
    tbl[0]  = '{1, 0, 0, 1, 1, 0, 1, 0};
    tbl[1]  = '{1, 1, 0, 1, 1, 0, 0, 0};
    tbl[2]  = '{1, 2, 0, 1, 1, 0, 0, 0};
    tbl[3]  = '{1, 3, 0, 1, 1, 0, 0, 0};
    tbl[4]  = '{1, 4, 0, 1, 1, 1, 0, 0};
    tbl[5]  = '{1, 5, 0, 0, 1, 1, 0, 0};
    tbl[6]  = '{1, 6, 0, 0, 1, 1, 0, 0};
    tbl[7]  = '{1, 7, 0, 1, 1, 1, 0, 0};
    tbl[8]  = '{1, 0, 1, 1, 1, 0, 0, 0};
    tbl[9]  = '{1, 1, 1, 1, 1, 0, 0, 0};
    tbl[10] = '{1, 2, 1, 1, 1, 0, 0, 0};
    tbl[11] = '{1, 3, 1, 1, 1, 0, 0, 0};
    tbl[12] = '{0, 3, 1, 1, 1, 0, 0, 0};
    tbl[13] = '{0, 3, 1, 1, 1, 0, 0, 0};
    tbl[14] = '{0, 3, 1, 1, 1, 0, 0, 0};
    tbl[15] = '{0, 3, 1, 1, 1, 0, 0, 0};
    tbl[16] = '{0, 3, 1, 1, 1, 0, 0, 0};
    tbl[17] = '{1, 4, 1, 1, 1, 1, 0, 0};
    tbl[18] = '{1, 5, 1, 0, 1, 1, 0, 0};

    rst  = 1'b1;
    en   = 1'b1;
    rst2 = 1'b1;
    en2  = 1'b1;
    #1;
    chk("reset hcount", int'(hc), 7);
    chk("reset vcount", int'(vc), 5);
    chk("reset hsync", int'(hs), 1);
    chk("reset vsync", int'(vs), 1);
    chk("reset blank", int'(bl), 1);
    chk("reset new_frame", int'(nf), 0);
    chk("reset frame_count", int'(fc), 0);
    chk("def reset hcount", int'(hc2), 1343);
    chk("def reset vcount", int'(vc2), 805);

    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First line, pause at h=3 and resume.
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].en);
      chk($sformatf("vec%0d hcount", i), int'(hc), tbl[i].h);
      chk($sformatf("vec%0d vcount", i), int'(vc), tbl[i].v);
      chk($sformatf("vec%0d hsync", i), int'(hs), int'(tbl[i].hs));
      chk($sformatf("vec%0d vsync", i), int'(vs), int'(tbl[i].vs));
      chk($sformatf("vec%0d blank", i), int'(bl), int'(tbl[i].bl));
      chk($sformatf("vec%0d new_frame", i), int'(nf), int'(tbl[i].nf));
      chk($sformatf("vec%0d frame_count", i), int'(fc), tbl[i].fc);
    end

    // Rest of the first frame, covering the vsync line.
    for (int n = 14; n < 48; n++) begin
      step(1'b1);
      chk_small_pos($sformatf("f0 n%0d", n), n);
    end

    // Second frame entry.
    step(1'b1);
    chk_small_pos("f1 entry", 48);
    chk("f1 entry frame_count", int'(fc), 1);

    // Pause at (0,0): strobe must not stretch.
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      chk($sformatf("pause00 %0d new_frame", i), int'(nf), 0);
      chk($sformatf("pause00 %0d hcount", i), int'(hc), 0);
      chk($sformatf("pause00 %0d vcount", i), int'(vc), 0);
    end
    step(1'b1);
    chk("resume00 hcount", int'(hc), 1);
    chk("resume00 new_frame", int'(nf), 0);
    chk("resume00 frame_count", int'(fc), 1);

    // Frames 2..64: one strobe per frame, counter wraps 63 -> 0.
    for (int f = 2; f <= 64; f++) begin
      pulses = 0;
      nsteps = (f == 2) ? 47 : 48;
      for (int s = 0; s < nsteps; s++) begin
        step(1'b1);
        pulses += int'(nf);
      end
      chk($sformatf("frame%0d pulses", f), pulses, 1);
      chk($sformatf("frame%0d entry hcount", f), int'(hc), 0);
      chk($sformatf("frame%0d entry vcount", f), int'(vc), 0);
      chk($sformatf("frame%0d new_frame", f), int'(nf), 1);
      chk($sformatf("frame%0d frame_count", f), int'(fc), f % 64);
    end

    // Move to (2,1), then reset asynchronously mid-cycle.
    for (int s = 0; s < 10; s++) step(1'b1);
    chk("pre-reset hcount", int'(hc), 2);
    chk("pre-reset vcount", int'(vc), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst hcount", int'(hc), 7);
    chk("async rst vcount", int'(vc), 5);
    chk("async rst hsync", int'(hs), 1);
    chk("async rst vsync", int'(vs), 1);
    chk("async rst blank", int'(bl), 1);
    chk("async rst new_frame", int'(nf), 0);
    chk("async rst frame_count", int'(fc), 0);
    #1;
    rst = 1'b0;
    step(1'b1);
    chk("post-rst hcount", int'(hc), 0);
    chk("post-rst vcount", int'(vc), 0);
    chk("post-rst new_frame", int'(nf), 1);
    chk("post-rst frame_count", int'(fc), 0);
    step(1'b1);
    chk("post-rst2 frame_count", int'(fc), 0);

    // Default parameters: one full line of horizontal timing.
    rst2 = 1'b0;
    for (int n = 0; n < 1344; n++) begin
      @(posedge clk);
      #1;
      chk($sformatf("def h%0d hcount", n), int'(hc2), n);
      chk($sformatf("def h%0d vcount", n), int'(vc2), 0);
      chk($sformatf("def h%0d hsync", n), int'(hs2), (n >= 1048 && n <= 1183) ? 0 : 1);
      chk($sformatf("def h%0d blank", n), int'(bl2), (n >= 1024) ? 1 : 0);
      chk($sformatf("def h%0d new_frame", n), int'(nf2), (n == 0) ? 1 : 0);
    end
    @(posedge clk);
    #1;
    chk("def line1 hcount", int'(hc2), 0);
    chk("def line1 vcount", int'(vc2), 1);
    chk("def line1 blank", int'(bl2), 0);
    chk("def line1 vsync", int'(vs2), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
